// File: rtl/dual_issue_sched.sv
// Dual-issue scheduler: takes a fetched pair and issues it on pipes A/B, or
// splits it over two cycles when the pair has a hazard or a resource conflict.
module dual_issue_sched #(
    parameter int PC_WIDTH  = 32,
    parameter int IWIDTH    = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 dis_clk,
    input  logic                 dis_rst,
    input  logic                 dis_i_ce,
    input  logic                 dis_i_valid,
    input  logic [PC_WIDTH-1:0]  dis_i_pc_1,
    input  logic [IWIDTH-1:0]    dis_i_instr_1,
    input  logic [PC_WIDTH-1:0]  dis_i_pc_2,
    input  logic [IWIDTH-1:0]    dis_i_instr_2,
    input  logic                 dis_i_stall,
    output logic                 dis_o_fetch_ready,
    output logic                 dis_o_valid_a,
    output logic [PC_WIDTH-1:0]  dis_o_pc_a,
    output logic [IWIDTH-1:0]    dis_o_instr_a,
    output logic                 dis_o_valid_b,
    output logic [PC_WIDTH-1:0]  dis_o_pc_b,
    output logic [IWIDTH-1:0]    dis_o_instr_b,
    output logic                 dis_o_change_instr,
    output logic [CNT_WIDTH-1:0] dis_o_pair_cnt,
    output logic [CNT_WIDTH-1:0] dis_o_split_cnt
);

    typedef enum logic {PAIR, SPLIT} state_t;

    state_t                state_q;
    logic                  valid_a_q, valid_b_q, change_q;
    logic [PC_WIDTH-1:0]   pc_a_q, pc_b_q, hold_pc_q;
    logic [IWIDTH-1:0]     instr_a_q, instr_b_q, hold_instr_q;
    logic [CNT_WIDTH-1:0]  pair_cnt_q, split_cnt_q;

    // Destination register; 0 means "no destination" ($0 never hazards anyway).
    function automatic logic [4:0] dest_of(input logic [IWIDTH-1:0] ins);
        case (ins[31:26])
            6'h00:                      dest_of = (ins[5:0] == 6'h08) ? 5'd0 : ins[15:11];
            6'h03:                      dest_of = 5'd31;
            6'h2B, 6'h04, 6'h05, 6'h02: dest_of = 5'd0;
            default:                    dest_of = ins[20:16];
        endcase
    endfunction

    function automatic logic is_mem(input logic [5:0] op);
        is_mem = (op == 6'h23) || (op == 6'h2B);
    endfunction

    function automatic logic is_ctrl(input logic [IWIDTH-1:0] ins);
        is_ctrl = (ins[31:26] inside {6'h02, 6'h03, 6'h04, 6'h05}) ||
                  (ins[31:26] == 6'h00 && ins[5:0] == 6'h08);
    endfunction

    logic [5:0] op1, op2;
    logic [4:0] dest1, dest2, rs2, rt2;
    logic       rs2_used, rt2_used, mem1, mem2, hazard, split, accept;

    assign op1      = dis_i_instr_1[31:26];
    assign op2      = dis_i_instr_2[31:26];
    assign rs2      = dis_i_instr_2[25:21];
    assign rt2      = dis_i_instr_2[20:16];
    assign dest1    = dest_of(dis_i_instr_1);
    assign dest2    = dest_of(dis_i_instr_2);
    assign rs2_used = !(op2 == 6'h02 || op2 == 6'h03);
    assign rt2_used = op2 inside {6'h00, 6'h2B, 6'h04, 6'h05};
    assign mem1     = is_mem(op1);
    assign mem2     = is_mem(op2);
    assign hazard   = (dest1 != 5'd0) &&
                      ((rs2_used && rs2 == dest1) || (rt2_used && rt2 == dest1) || dest2 == dest1);
    assign split    = hazard || (mem1 && mem2) || is_ctrl(dis_i_instr_1) || is_ctrl(dis_i_instr_2);

    assign dis_o_fetch_ready = !dis_rst && dis_i_ce && !dis_i_stall && (state_q == PAIR);
    assign accept            = dis_i_valid && dis_o_fetch_ready;

    always_ff @(posedge dis_clk) begin
        if (dis_rst) begin
            state_q      <= PAIR;
            valid_a_q    <= 1'b0;
            valid_b_q    <= 1'b0;
            change_q     <= 1'b0;
            pc_a_q       <= '0;
            pc_b_q       <= '0;
            instr_a_q    <= '0;
            instr_b_q    <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
            pair_cnt_q   <= '0;
            split_cnt_q  <= '0;
        end else if (dis_i_ce && !dis_i_stall) begin
            case (state_q)
                PAIR: begin
                    if (accept && !split) begin
                        valid_a_q  <= 1'b1;
                        valid_b_q  <= 1'b1;
                        pair_cnt_q <= pair_cnt_q + 1'b1;
                        // Only pipe A has a memory port, so a lone younger mem op swaps in.
                        if (mem2 && !mem1) begin
                            pc_a_q    <= dis_i_pc_2;
                            instr_a_q <= dis_i_instr_2;
                            pc_b_q    <= dis_i_pc_1;
                            instr_b_q <= dis_i_instr_1;
                            change_q  <= 1'b1;
                        end else begin
                            pc_a_q    <= dis_i_pc_1;
                            instr_a_q <= dis_i_instr_1;
                            pc_b_q    <= dis_i_pc_2;
                            instr_b_q <= dis_i_instr_2;
                            change_q  <= 1'b0;
                        end
                    end else if (accept) begin
                        valid_a_q    <= 1'b1;
                        valid_b_q    <= 1'b0;
                        change_q     <= 1'b0;
                        pc_a_q       <= dis_i_pc_1;
                        instr_a_q    <= dis_i_instr_1;
                        hold_pc_q    <= dis_i_pc_2;
                        hold_instr_q <= dis_i_instr_2;
                        split_cnt_q  <= split_cnt_q + 1'b1;
                        state_q      <= SPLIT;
                    end else begin
                        valid_a_q <= 1'b0;
                        valid_b_q <= 1'b0;
                    end
                end
                SPLIT: begin
                    valid_a_q <= 1'b1;
                    valid_b_q <= 1'b0;
                    change_q  <= 1'b0;
                    pc_a_q    <= hold_pc_q;
                    instr_a_q <= hold_instr_q;
                    state_q   <= PAIR;
                end
                default: state_q <= PAIR;
            endcase
        end
    end

    assign dis_o_valid_a      = valid_a_q;
    assign dis_o_pc_a         = pc_a_q;
    assign dis_o_instr_a      = instr_a_q;
    assign dis_o_valid_b      = valid_b_q;
    assign dis_o_pc_b         = pc_b_q;
    assign dis_o_instr_b      = instr_b_q;
    assign dis_o_change_instr = change_q;
    assign dis_o_pair_cnt     = pair_cnt_q;
    assign dis_o_split_cnt    = split_cnt_q;

endmodule
